// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-ported memory between the fetch and data ports,
// with registered responses and a sticky watchdog for a memory that never acknowledges.
module mem_arbiter #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_LEN = 8
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            imem_req,
    input  logic [XLEN-1:0] imem_addr,
    output logic [XLEN-1:0] imem_rdata,
    output logic            imem_ack,
    input  logic            dmem_req,
    input  logic            dmem_we,
    input  logic [XLEN-1:0] dmem_addr,
    input  logic [XLEN-1:0] dmem_wdata,
    output logic [XLEN-1:0] dmem_rdata,
    output logic            dmem_ack,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            mem_ack,
    output logic            error
);

    localparam logic [CNT_LEN-1:0] TimeoutLast = CNT_LEN'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StAccess, StResp, StError} state_t;

    state_t               state;
    logic                 last_grant;   // 0 = imem, 1 = dmem
    logic                 granted_dmem;
    logic [CNT_LEN-1:0]   cnt;
    logic                 pick_dmem;

    // On contention the port that did not win last time goes first.
    assign pick_dmem = dmem_req && (!imem_req || !last_grant);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= StIdle;
            last_grant   <= 1'b1;
            granted_dmem <= 1'b0;
            cnt          <= '0;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            imem_rdata   <= '0;
            imem_ack     <= 1'b0;
            dmem_rdata   <= '0;
            dmem_ack     <= 1'b0;
            error        <= 1'b0;
        end else begin
            imem_ack <= 1'b0;
            dmem_ack <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (imem_req || dmem_req) begin
                        mem_req      <= 1'b1;
                        mem_we       <= pick_dmem & dmem_we;
                        mem_addr     <= pick_dmem ? dmem_addr : imem_addr;
                        mem_wdata    <= pick_dmem ? dmem_wdata : '0;
                        cnt          <= '0;
                        last_grant   <= pick_dmem;
                        granted_dmem <= pick_dmem;
                        state        <= StAccess;
                    end
                end
                StAccess: begin
                    // An ack in the final watchdog cycle still wins over the timeout.
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        if (granted_dmem) begin
                            dmem_ack   <= 1'b1;
                            dmem_rdata <= mem_we ? '0 : mem_rdata;
                        end else begin
                            imem_ack   <= 1'b1;
                            imem_rdata <= mem_rdata;
                        end
                        state <= StResp;
                    end else if ((TIMEOUT != 0) && (cnt == TimeoutLast)) begin
                        mem_req <= 1'b0;
                        error   <= 1'b1;
                        state   <= StError;
                    end else begin
                        cnt <= cnt + CNT_LEN'(1);
                    end
                end
                StResp: begin
                    state <= StIdle;
                end
                StError: begin
                    mem_req <= 1'b0;
                    error   <= 1'b1;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a TIMEOUT=8 instance and a TIMEOUT=0 instance share stimulus,
// a behavioural memory answers whichever instance is selected.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        imem_req = 1'b0;
    logic [31:0] imem_addr = '0;
    logic        dmem_req = 1'b0;
    logic        dmem_we = 1'b0;
    logic [31:0] dmem_addr = '0;
    logic [31:0] dmem_wdata = '0;
    logic [31:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;

    logic [31:0] a_imem_rdata, a_dmem_rdata, a_mem_addr, a_mem_wdata;
    logic        a_imem_ack, a_dmem_ack, a_mem_req, a_mem_we, a_error;
    logic [31:0] b_imem_rdata, b_dmem_rdata, b_mem_addr, b_mem_wdata;
    logic        b_imem_ack, b_dmem_ack, b_mem_req, b_mem_we, b_error;

    mem_arbiter #(.XLEN(32), .TIMEOUT(8), .CNT_LEN(8)) u_dut8 (
        .clk(clk), .reset_n(reset_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(a_imem_rdata),
        .imem_ack(a_imem_ack), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_rdata(a_dmem_rdata),
        .dmem_ack(a_dmem_ack), .mem_req(a_mem_req), .mem_we(a_mem_we),
        .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .mem_rdata(mem_rdata),
        .mem_ack(mem_ack), .error(a_error)
    );

    mem_arbiter #(.XLEN(32), .TIMEOUT(0), .CNT_LEN(8)) u_dut0 (
        .clk(clk), .reset_n(reset_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(b_imem_rdata),
        .imem_ack(b_imem_ack), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_rdata(b_dmem_rdata),
        .dmem_ack(b_dmem_ack), .mem_req(b_mem_req), .mem_we(b_mem_we),
        .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_rdata(mem_rdata),
        .mem_ack(mem_ack), .error(b_error)
    );

    always #5 clk = ~clk;

    // Selected instance as seen by the memory model and the monitor.
    logic        sel = 1'b0;
    logic [31:0] o_imem_rdata, o_dmem_rdata, o_mem_addr, o_mem_wdata;
    logic        o_imem_ack, o_dmem_ack, o_mem_req, o_mem_we;
    assign o_imem_rdata = sel ? b_imem_rdata : a_imem_rdata;
    assign o_dmem_rdata = sel ? b_dmem_rdata : a_dmem_rdata;
    assign o_mem_addr   = sel ? b_mem_addr   : a_mem_addr;
    assign o_mem_wdata  = sel ? b_mem_wdata  : a_mem_wdata;
    assign o_imem_ack   = sel ? b_imem_ack   : a_imem_ack;
    assign o_dmem_ack   = sel ? b_dmem_ack   : a_dmem_ack;
    assign o_mem_req    = sel ? b_mem_req    : a_mem_req;
    assign o_mem_we     = sel ? b_mem_we     : a_mem_we;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return (a == 32'h100) ? 32'h13 : (a ^ 32'h5A5A_1234);
    endfunction

    typedef struct {
        bit          port;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc = 0;
    int   ack_count = 0;
    int   mem_lat = 1;
    int   acc = 0;
    int   req_cycles = 0;
    logic [31:0] cmd_addr, cmd_wdata;
    logic        cmd_we;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: acks in the mem_lat-th cycle of mem_req; mem_lat = 0 never acks.
    always @(negedge clk) begin
        if (mem_ack) begin
            mem_ack = 1'b0;
            acc = 0;
        end else if (o_mem_req) begin
            if (acc == 0) begin
                cmd_addr  = o_mem_addr;
                cmd_we    = o_mem_we;
                cmd_wdata = o_mem_wdata;
            end else begin
                check("cmd_stable", {o_mem_we, o_mem_addr, o_mem_wdata},
                      {cmd_we, cmd_addr, cmd_wdata});
            end
            acc++;
            req_cycles++;
            if (acc == mem_lat) begin
                mem_ack   = 1'b1;
                mem_rdata = o_mem_we ? 32'hBAD0_BAD0 : mem_fn(o_mem_addr);
            end
        end else begin
            acc = 0;
        end
    end

    // Response monitor: every ack pops the oldest expectation.
    always @(negedge clk) begin
        if (reset_n && (o_imem_ack || o_dmem_ack)) begin
            ack_count++;
            check("ack_onehot", o_imem_ack & o_dmem_ack, 0);
            check("ack_expected", sb.size() != 0, 1);
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                check("ack_port", o_dmem_ack, mon_e.port);
                check("ack_rdata", mon_e.port ? o_dmem_rdata : o_imem_rdata, mon_e.data);
            end
        end
    end

    task automatic push_exp(input bit port, input logic [31:0] addr, input bit we);
        exp_t x;
        x.port = port;
        x.data = (port && we) ? 32'h0 : mem_fn(addr);
        sb.push_back(x);
    endtask

    task automatic do_reset();
        reset_n  = 1'b0;
        imem_req = 1'b0;
        dmem_req = 1'b0;
        sb.delete();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    // One transaction on one port; latency counts edges from request to the ack.
    task automatic issue(input bit port, input logic [31:0] addr, input bit we,
                         input logic [31:0] wdata, input int lat, output int latency);
        int start;
        bit got;
        @(negedge clk);
        mem_lat = lat;
        req_cycles = 0;
        if (port) begin
            dmem_req = 1'b1; dmem_we = we; dmem_addr = addr; dmem_wdata = wdata;
        end else begin
            imem_req = 1'b1; imem_addr = addr;
        end
        push_exp(port, addr, we);
        start = cyc;
        got = 1'b0;
        for (int i = 0; i < lat + 20 && !got; i++) begin
            @(negedge clk);
            got = port ? o_dmem_ack : o_imem_ack;
        end
        check("ack_seen", got, 1);
        latency = cyc - start;
        imem_req = 1'b0;
        dmem_req = 1'b0;
    endtask

    initial begin
        int lat;
        int base;
        #1;
        check("rst_mem_addr", a_mem_addr, 0);
        check("rst_mem_wdata", a_mem_wdata, 0);
        check("rst_imem_rdata", a_imem_rdata, 0);
        check("rst_dmem_rdata", a_dmem_rdata, 0);
        check("rst_flags", {a_mem_req, a_mem_we, a_imem_ack, a_dmem_ack, a_error}, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        issue(0, 32'h100, 0, 0, 1, lat);
        check("fetch_latency", lat, 2);
        check("fetch_cmd", {cmd_we, cmd_addr}, {1'b0, 32'h100});

        issue(1, 32'h2000, 1, 32'hDEAD_BEEF, 4, lat);
        check("store_latency", lat, 5);
        check("store_req_cycles", req_cycles, 4);
        check("store_cmd", {cmd_we, cmd_addr, cmd_wdata}, {1'b1, 32'h2000, 32'hDEAD_BEEF});
        check("imem_rdata_hold", a_imem_rdata, 32'h13);

        // Contention: both held, imem must win first, then strict alternation.
        @(negedge clk);
        mem_lat = 1;
        base = ack_count;
        imem_req = 1'b1; imem_addr = 32'h400;
        dmem_req = 1'b1; dmem_we = 1'b0; dmem_addr = 32'h500;
        push_exp(0, 32'h400, 0); push_exp(1, 32'h500, 0);
        push_exp(0, 32'h400, 0); push_exp(1, 32'h500, 0);
        for (int i = 0; i < 40 && ack_count < base + 4; i++) @(negedge clk);
        imem_req = 1'b0;
        dmem_req = 1'b0;
        check("contention_acks", ack_count - base, 4);
        repeat (3) @(negedge clk);

        issue(0, 32'h700, 0, 0, 8, lat);
        check("ack_at_timeout_latency", lat, 9);
        check("ack_at_timeout_error", a_error, 0);

        // Watchdog: memory silent.
        do_reset();
        @(negedge clk);
        mem_lat = 0;
        req_cycles = 0;
        imem_req = 1'b1; imem_addr = 32'h300;
        repeat (8) @(negedge clk);
        check("wd_error_before", a_error, 0);
        @(negedge clk);
        check("wd_error", a_error, 1);
        check("wd_mem_req", a_mem_req, 0);
        check("wd_req_cycles", req_cycles, 8);
        base = ack_count;
        dmem_req = 1'b1; dmem_addr = 32'h304;
        repeat (10) @(negedge clk);
        check("wd_no_acks", ack_count - base, 0);
        check("wd_stuck", {a_error, a_mem_req}, 2'b10);
        do_reset();
        #1;
        check("wd_reset_error", a_error, 0);
        issue(0, 32'h310, 0, 0, 1, lat);
        check("wd_after_reset_latency", lat, 2);

        // Reset in the middle of ACCESS.
        @(negedge clk);
        mem_lat = 0;
        dmem_req = 1'b1; dmem_we = 1'b0; dmem_addr = 32'h600;
        repeat (3) @(negedge clk);
        check("mid_req_before", a_mem_req, 1);
        #2;
        reset_n = 1'b0;
        dmem_req = 1'b0;
        #1;
        check("async_reset_req", a_mem_req, 0);
        check("async_reset_addr", a_mem_addr, 0);
        @(negedge clk);
        reset_n = 1'b1;
        issue(1, 32'h640, 0, 0, 2, lat);
        check("after_abort_latency", lat, 3);

        // Watchdog disabled: a very slow memory still completes.
        do_reset();
        sel = 1'b1;
        issue(1, 32'h800, 0, 0, 300, lat);
        check("t0_latency", lat, 301);
        check("t0_error", b_error, 0);
        check("t8_error_same_stim", a_error, 1);

        repeat (3) @(negedge clk);
        check("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
